// File: rtl/vid_timing_pkg.sv
// Shared raster timing defaults, FSM state encoding and pixel type for the
// avg filter front-end frame sequencer.
package vid_timing_pkg;

    // 720p60 raster, counted in pixel clocks / lines
    localparam int VT_H_SYNC  = 40;
    localparam int VT_H_BACK  = 220;
    localparam int VT_H_DISP  = 1280;
    localparam int VT_H_FRONT = 110;
    localparam int VT_H_TOTAL = 1650;
    localparam int VT_V_SYNC  = 5;
    localparam int VT_V_BACK  = 20;
    localparam int VT_V_DISP  = 720;
    localparam int VT_V_FRONT = 5;
    localparam int VT_V_TOTAL = 750;

    localparam int PIX_W = 8;
    localparam int FCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } frame_state_t;

    typedef logic [PIX_W-1:0] pixel_t;

    // Counter width able to hold 0..total-1, never narrower than one bit
    function automatic int cnt_w(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/avg_filter_frame_ctrl_if.sv
// Pixel stream bundle: upstream valid/ready source in, raster-timed pixels out
// towards the filter. The master is the frame sequencer.
interface avg_filter_frame_ctrl_if;
    import vid_timing_pkg::*;

    logic   src_valid;
    pixel_t src_data;
    logic   src_ready;

    logic   pre_img_vsync;
    logic   pre_img_hsync;
    logic   pre_img_valid;
    pixel_t pre_img_data;

    modport master (
        input  src_valid,
        input  src_data,
        output src_ready,
        output pre_img_vsync,
        output pre_img_hsync,
        output pre_img_valid,
        output pre_img_data
    );

    modport slave (
        output src_valid,
        output src_data,
        input  src_ready,
        input  pre_img_vsync,
        input  pre_img_hsync,
        input  pre_img_valid,
        input  pre_img_data
    );

endinterface

// File: rtl/vid_raster_cnt.sv
// Horizontal/vertical raster position counters with end-of-line and
// end-of-frame flags. Both counters sit at 0 whenever the enable is low.
module vid_raster_cnt #(
    parameter int H_TOTAL = 1650,
    parameter int V_TOTAL = 750,
    parameter int HW      = 11,
    parameter int VW      = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_eol,
    output logic          o_eof
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_eol;
    logic          w_eof;

    assign w_eol = (r_h_cnt == H_LAST);
    assign w_eof = w_eol && (r_v_cnt == V_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_eol) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_eof ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    assign o_h_cnt = r_h_cnt;
    assign o_v_cnt = r_v_cnt;
    assign o_eol   = w_eol;
    assign o_eof   = w_eof;

endmodule

// File: rtl/avg_filter_frame_ctrl.sv
// Frame sequencer ahead of the avg filter: raster timing generation, gated
// pixel pull from the upstream source, run/drain control and status.
module avg_filter_frame_ctrl
    import vid_timing_pkg::*;
#(
    parameter int H_SYNC  = VT_H_SYNC,
    parameter int H_BACK  = VT_H_BACK,
    parameter int H_DISP  = VT_H_DISP,
    parameter int H_FRONT = VT_H_FRONT,
    parameter int H_TOTAL = VT_H_TOTAL,
    parameter int V_SYNC  = VT_V_SYNC,
    parameter int V_BACK  = VT_V_BACK,
    parameter int V_DISP  = VT_V_DISP,
    parameter int V_FRONT = VT_V_FRONT,
    parameter int V_TOTAL = VT_V_TOTAL
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_stop,
    avg_filter_frame_ctrl_if.master    vif,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic [FCNT_W-1:0]          o_frame_cnt,
    output logic                       o_underflow
);

    localparam int HW = cnt_w(H_TOTAL);
    localparam int VW = cnt_w(V_TOTAL);

    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_DISP);

    frame_state_t r_state;
    frame_state_t w_state_nxt;

    logic [HW-1:0] w_h_cnt;
    logic [VW-1:0] w_v_cnt;
    logic          w_eol;
    logic          w_eof;
    logic          w_frame_end;
    logic          w_run;
    logic          w_start_acc;
    logic          w_vsync;
    logic          w_hsync;
    logic          w_active;
    logic          w_xfer;

    logic          r_vsync;
    logic          r_hsync;
    logic          r_valid;
    pixel_t        r_data;
    logic          r_frame_done;
    logic [FCNT_W-1:0] r_frame_cnt;
    logic          r_underflow;

    assign w_run = (r_state != IDLE);

    vid_raster_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_raster (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_run),
        .o_h_cnt (w_h_cnt),
        .o_v_cnt (w_v_cnt),
        .o_eol   (w_eol),
        .o_eof   (w_eof)
    );

    assign w_frame_end = w_run && w_eol && w_eof;

    // Frame control
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = i_stop ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_frame_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timing decode is gated by w_run so the (0,0) hold value in IDLE emits nothing
    assign w_vsync  = w_run && (w_v_cnt < V_SYNC_END);
    assign w_hsync  = w_run && (w_h_cnt < H_SYNC_END);
    assign w_active = w_run
                   && (w_h_cnt >= H_ACT_BEG) && (w_h_cnt < H_ACT_END)
                   && (w_v_cnt >= V_ACT_BEG) && (w_v_cnt < V_ACT_END);

    assign vif.src_ready = w_active;
    assign w_xfer        = w_active && vif.src_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vsync      <= 1'b0;
            r_hsync      <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_underflow  <= 1'b0;
        end else begin
            r_vsync      <= w_vsync;
            r_hsync      <= w_hsync;
            r_valid      <= w_active;
            r_data       <= w_xfer ? vif.src_data : '0;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            // A starved active slot still goes out as a zero pixel; only the flag records it
            if (w_start_acc) begin
                r_underflow <= 1'b0;
            end else if (w_active && !vif.src_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign vif.pre_img_vsync = r_vsync;
    assign vif.pre_img_hsync = r_hsync;
    assign vif.pre_img_valid = r_valid;
    assign vif.pre_img_data  = r_data;

    assign o_busy       = w_run;
    assign o_frame_done = r_frame_done;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_avg_filter_frame_ctrl.sv
// Directed bench for the frame sequencer on a 10x6 raster (H 2/2/4/2, V 1/1/3/1).
module tb_avg_filter_frame_ctrl;
    import vid_timing_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        underflow;

    avg_filter_frame_ctrl_if sif ();

    avg_filter_frame_ctrl #(
        .H_SYNC (2), .H_BACK (2), .H_DISP (4), .H_FRONT (2), .H_TOTAL (10),
        .V_SYNC (1), .V_BACK (1), .V_DISP (3), .V_FRONT (1), .V_TOTAL (6)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .vif          (sif),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_frame_cnt  (frame_cnt),
        .o_underflow  (underflow)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int t, t_end, pat, slot_idx, pix_k, drop_slot, nvalid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vsync"}, sif.pre_img_vsync, 0);
        chk({tag, "_hsync"}, sif.pre_img_hsync, 0);
        chk({tag, "_valid"}, sif.pre_img_valid, 0);
        chk({tag, "_data"},  sif.pre_img_data, 0);
        chk({tag, "_ready"}, sif.src_ready, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_fdone"}, frame_done, 0);
        chk({tag, "_fcnt"},  frame_cnt, 0);
        chk({tag, "_uflow"}, underflow, 0);
    endtask

    // Output cycle t shows raster position t-1 of a 60-clock frame
    task automatic run_cycles(input int n);
        int p, h, v, q, hq, vq, ed;
        bit on, e_act, e_rdy;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t++;
            on = (t >= 1) && (t <= t_end);
            p = (t - 1) % 60; h = p % 10; v = p / 10;
            e_act = on && h >= 4 && h < 8 && v >= 2 && v < 5;
            q = t % 60; hq = q % 10; vq = q / 10;
            e_rdy = (t < t_end) && hq >= 4 && hq < 8 && vq >= 2 && vq < 5;
            if (!e_act)                 ed = 0;
            else if (pix_k == drop_slot) ed = 0;
            else if (pix_k > drop_slot)  ed = (pix_k - 1) & 8'hFF;
            else                         ed = pix_k & 8'hFF;
            chk("vsync", sif.pre_img_vsync, on && v < 1);
            chk("hsync", sif.pre_img_hsync, on && h < 2);
            chk("valid", sif.pre_img_valid, e_act);
            chk("data",  sif.pre_img_data, ed);
            chk("fdone", frame_done, on && p == 59);
            chk("busy",  busy, t < t_end);
            chk("fcnt",  frame_cnt, ((t < t_end) ? t : t_end) / 60);
            chk("ready", sif.src_ready, e_rdy);
            if (e_act) pix_k++;
            if (sif.pre_img_valid) nvalid++;
            sif.src_data = pat[7:0];
            if (sif.src_ready) begin
                sif.src_valid = (slot_idx != drop_slot);
                if (sif.src_valid) pat++;
                slot_idx++;
            end else begin
                sif.src_valid = 1'b1;
            end
        end
    endtask

    task automatic go(input bit with_stop, input int tend);
        @(negedge clk);
        start = 1'b1; stop = with_stop;
        t_end = tend; pat = 0; slot_idx = 0; pix_k = 0; nvalid = 0;
        sif.src_valid = 1'b1; sif.src_data = 8'h00;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; t = 0;
        chk("busy_t0", busy, 1);
        chk("vsync_t0", sif.pre_img_vsync, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drop_slot = 1000;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        sif.src_valid = 1'b0; sif.src_data = 8'h00;
        drop_slot = 1000; t = 0; t_end = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Continuous frames, always-valid source
        go(1'b0, 1 << 30);
        run_cycles(185);
        chk("t1_npix", nvalid, 36);
        chk("t1_fcnt", frame_cnt, 3);

        // Stop in the middle of frame 2: frame 2 still completes
        do_reset();
        go(1'b0, 120);
        run_cycles(90);
        stop = 1'b1;
        run_cycles(1);
        stop = 1'b0;
        run_cycles(49);
        chk("t2_npix", nvalid, 24);
        chk("t2_fcnt", frame_cnt, 2);

        // Single frame via start&stop together
        do_reset();
        go(1'b1, 60);
        run_cycles(80);
        chk("t3_npix", nvalid, 12);
        chk("t3_fcnt", frame_cnt, 1);
        chk("t3_busy", busy, 0);

        // Source starves the third active slot
        do_reset();
        drop_slot = 2;
        go(1'b1, 60);
        run_cycles(26);
        chk("t4_uf_before", underflow, 0);
        run_cycles(1);
        chk("t4_uf_set", underflow, 1);
        run_cycles(43);
        chk("t4_uf_sticky", underflow, 1);
        chk("t4_npix", nvalid, 12);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4_uf_clr", underflow, 0);
        chk("t4_busy", busy, 1);

        // Reset in the middle of line v=3, then clean restart
        do_reset();
        go(1'b0, 1 << 30);
        run_cycles(33);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("t5_rst");
        rst = 1'b0;
        drop_slot = 1000;
        go(1'b0, 1 << 30);
        run_cycles(30);
        chk("t5_npix", nvalid, 4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
